// File: rtl/scs8hd_scan_seq_if.sv
// Scan-sequencer bus interface.
// Groups the pattern-source handshake and the scan-chain signals of
// scs8hd_scan_seq. CLK and RESET stay plain ports on the sequencer.
//   start   - request one pattern (pattern source -> sequencer)
//   pat     - load pattern, bit i for chain cell i
//   exp     - expected captured response, bit i for cell i
//   so      - Q of the last chain cell (chain -> sequencer)
//   sce     - scan enable to all cells (1 = shift)
//   scd     - scan data into cell 0
//   busy    - pattern in progress
//   done    - one-cycle pulse, resp/fail valid
//   resp    - unloaded response, bit i = value captured by cell i
//   fail    - resp differed from the latched expected data
//   err_cnt - saturating count of failing patterns
// master: pattern source / chain side.  slave: the sequencer.
interface scs8hd_scan_seq_if #(
    parameter int CHAIN_LEN = 8
);
    logic                 start;
    logic [CHAIN_LEN-1:0] pat;
    logic [CHAIN_LEN-1:0] exp;
    logic                 so;
    logic                 sce;
    logic                 scd;
    logic                 busy;
    logic                 done;
    logic [CHAIN_LEN-1:0] resp;
    logic                 fail;
    logic [7:0]           err_cnt;

    modport master (
        output start, pat, exp, so,
        input  sce, scd, busy, done, resp, fail, err_cnt
    );

    modport slave (
        input  start, pat, exp, so,
        output sce, scd, busy, done, resp, fail, err_cnt
    );
endinterface

// File: rtl/scs8hd_scan_seq.sv
// Scan-chain sequencer.
// One accepted start runs a full pattern: N shift cycles loading pat
// (MSB first), one capture cycle with sce low, N unload cycles sampling
// so into resp (zero-filling scd), then a compare against exp.
// Ports:
//   CLK   - rising-edge clock, shared with the scan chain
//   RESET - asynchronous, active-high reset
//   bus   - scs8hd_scan_seq_if slave modport (see interface header)
// All outputs are driven directly from flops; sce is therefore glitch-free.
module scs8hd_scan_seq #(
    parameter int CHAIN_LEN = 8,
    parameter int CNT_W     = 6
) (
    input  logic                 CLK,
    input  logic                 RESET,
    scs8hd_scan_seq_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CAPTURE,
        UNLOAD
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    // Remaining pattern bits below the one currently on scd, MSB next.
    logic [CHAIN_LEN-2:0] pat_sh;
    logic [CHAIN_LEN-1:0] exp_q;
    logic                 sce_q;
    logic                 scd_q;
    logic                 busy_q;
    logic                 done_q;
    logic [CHAIN_LEN-1:0] resp_q;
    logic                 fail_q;
    logic [7:0]           err_q;
    logic [CHAIN_LEN-1:0] resp_nxt;

    // Samples shift in at the LSB; after N samples the first one (cell N-1)
    // has reached resp[N-1], giving bit i = cell i.
    always_comb begin
        resp_nxt = {resp_q[CHAIN_LEN-2:0], bus.so};
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= IDLE;
            cnt    <= '0;
            pat_sh <= '0;
            exp_q  <= '0;
            sce_q  <= 1'b0;
            scd_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            resp_q <= '0;
            fail_q <= 1'b0;
            err_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // First shift bit goes straight onto scd so it is
                        // present in the cycle after the accepting edge.
                        scd_q  <= bus.pat[CHAIN_LEN-1];
                        pat_sh <= bus.pat[CHAIN_LEN-2:0];
                        exp_q  <= bus.exp;
                        sce_q  <= 1'b1;
                        busy_q <= 1'b1;
                        resp_q <= '0;
                        cnt    <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt == LAST) begin
                        sce_q <= 1'b0;
                        scd_q <= 1'b0;
                        state <= CAPTURE;
                    end else begin
                        scd_q  <= pat_sh[CHAIN_LEN-2];
                        pat_sh <= pat_sh << 1;
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                CAPTURE: begin
                    sce_q <= 1'b1;
                    scd_q <= 1'b0;
                    cnt   <= '0;
                    state <= UNLOAD;
                end
                UNLOAD: begin
                    resp_q <= resp_nxt;
                    if (cnt == LAST) begin
                        state  <= IDLE;
                        sce_q  <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        fail_q <= (resp_nxt != exp_q);
                        if ((resp_nxt != exp_q) && (err_q != 8'hFF)) begin
                            err_q <= err_q + 8'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sce     = sce_q;
    assign bus.scd     = scd_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.resp    = resp_q;
    assign bus.fail    = fail_q;
    assign bus.err_cnt = err_q;
endmodule

// File: tb/tb_scs8hd_scan_seq.sv
// Testbench for scs8hd_scan_seq (N = 8).
// A behavioural 8-cell scan chain sits around the sequencer: with sce high
// it shifts (cell 0 <- scd, cell i+1 <- cell i); with sce low it loads its
// D inputs, which are either cell-index parity (0xAA) or its own Q
// (loopback). so is cell 7.
module tb_scs8hd_scan_seq;
    logic CLK;
    logic RESET;
    int   total;
    int   bad;

    scs8hd_scan_seq_if #(.CHAIN_LEN(8)) bus ();

    scs8hd_scan_seq #(.CHAIN_LEN(8), .CNT_W(6)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [7:0] chain;
    logic       loopback;

    initial chain = 8'h5A;
    always @(posedge CLK) begin
        if (bus.sce) chain <= {chain[6:0], bus.scd};
        else         chain <= loopback ? chain : 8'hAA;
    end
    assign bus.so = chain[7];

    typedef struct {
        logic [7:0] pat;
        logic [7:0] exp;
        logic       lb;
        logic [7:0] resp;
        logic       fail;
        logic [7:0] err;
    } vec_t;

    vec_t vt[7];

    // Per-cycle traces: bit k holds the value observed after edge tk.
    localparam logic [39:0] SCE_EXP  = 40'h1FEFF;  // shift k0-7, capture k8, unload k9-16
    localparam logic [39:0] BUSY_EXP = 40'h1FFFF;  // k0..k16
    localparam logic [39:0] DONE_EXP = 40'h20000;  // k17 only

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Called at a negedge. Drives start with p/e, then observes ncyc cycles.
    task automatic run_pat(input logic [7:0] p, input logic [7:0] e, input logic lb,
                           input logic [39:0] rmask, input int ncyc,
                           output logic [7:0] scd_word, output logic [7:0] resp0,
                           output logic [39:0] sce_tr, output logic [39:0] busy_tr,
                           output logic [39:0] done_tr);
        scd_word = '0;
        resp0    = '0;
        sce_tr   = '0;
        busy_tr  = '0;
        done_tr  = '0;
        bus.pat   = p;
        bus.exp   = e;
        loopback  = lb;
        bus.start = 1'b1;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            sce_tr[k]  = bus.sce;
            busy_tr[k] = bus.busy;
            done_tr[k] = bus.done;
            if (k < 8) scd_word = {scd_word[6:0], bus.scd};
            if (k == 0) resp0 = bus.resp;
            bus.start = rmask[k];
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " sce"},  64'(bus.sce),     64'd0);
        check({tag, " scd"},  64'(bus.scd),     64'd0);
        check({tag, " busy"}, 64'(bus.busy),    64'd0);
        check({tag, " done"}, 64'(bus.done),    64'd0);
        check({tag, " resp"}, 64'(bus.resp),    64'd0);
        check({tag, " fail"}, 64'(bus.fail),    64'd0);
        check({tag, " err"},  64'(bus.err_cnt), 64'd0);
    endtask

    task automatic check_no_done(input string tag, input int ncyc);
        int ndone;
        ndone = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge CLK);
            if (bus.done) ndone++;
        end
        check({tag, " no done"}, 64'(ndone), 64'd0);
        check({tag, " idle busy"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        logic [7:0]  scd_word;
        logic [7:0]  resp0;
        logic [39:0] sce_tr;
        logic [39:0] busy_tr;
        logic [39:0] done_tr;
        int          exp_err;

        total     = 0;
        bad       = 0;
        RESET     = 1'b1;
        bus.start = 1'b0;
        bus.pat   = '0;
        bus.exp   = '0;
        loopback  = 1'b0;

        //           pat    exp    lb    resp   fail  err
        vt[0] = '{8'hA5, 8'hAA, 1'b0, 8'hAA, 1'b0, 8'd0};
        vt[1] = '{8'hA5, 8'h55, 1'b0, 8'hAA, 1'b1, 8'd1};
        vt[2] = '{8'h3C, 8'h3C, 1'b1, 8'h3C, 1'b0, 8'd1};
        vt[3] = '{8'h81, 8'h00, 1'b1, 8'h81, 1'b1, 8'd2};
        vt[4] = '{8'h00, 8'hAA, 1'b0, 8'hAA, 1'b0, 8'd2};
        vt[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b0, 8'd2};
        vt[6] = '{8'h01, 8'h01, 1'b1, 8'h01, 1'b0, 8'd2};

        repeat (2) @(negedge CLK);
        check_reset_outputs("reset");
        RESET = 1'b0;
        @(negedge CLK);

        // Each run begins at the negedge of the previous DONE cycle, so every
        // run after the first also exercises START during DONE.
        for (int i = 0; i < 7; i++) begin
            run_pat(vt[i].pat, vt[i].exp, vt[i].lb, 40'd0, 18,
                    scd_word, resp0, sce_tr, busy_tr, done_tr);
            check($sformatf("v%0d scd order", i), 64'(scd_word), 64'(vt[i].pat));
            check($sformatf("v%0d resp clr", i),  64'(resp0),    64'd0);
            check($sformatf("v%0d sce trace", i), 64'(sce_tr),   64'(SCE_EXP));
            check($sformatf("v%0d busy trace", i), 64'(busy_tr), 64'(BUSY_EXP));
            check($sformatf("v%0d done trace", i), 64'(done_tr), 64'(DONE_EXP));
            check($sformatf("v%0d resp", i), 64'(bus.resp),    64'(vt[i].resp));
            check($sformatf("v%0d fail", i), 64'(bus.fail),    64'(vt[i].fail));
            check($sformatf("v%0d err", i),  64'(bus.err_cnt), 64'(vt[i].err));
        end

        // START re-pulsed at cycles 3 and 10 of a run: ignored, one DONE.
        run_pat(8'h5A, 8'h5A, 1'b1, 40'h408, 26,
                scd_word, resp0, sce_tr, busy_tr, done_tr);
        check("ign busy trace", 64'(busy_tr), 64'(BUSY_EXP));
        check("ign done trace", 64'(done_tr), 64'(DONE_EXP));
        check("ign sce trace",  64'(sce_tr),  64'(SCE_EXP));
        check("ign resp", 64'(bus.resp), 64'h5A);
        check("ign fail", 64'(bus.fail), 64'd0);
        check("ign err",  64'(bus.err_cnt), 64'd2);

        // RESET in the 5th SHIFT cycle.
        bus.pat = 8'hA5; bus.exp = 8'hAA; loopback = 1'b0; bus.start = 1'b1;
        @(posedge CLK); @(negedge CLK);
        bus.start = 1'b0;
        repeat (4) begin @(posedge CLK); @(negedge CLK); end
        check("rst1 pre sce", 64'(bus.sce), 64'd1);
        RESET = 1'b1;
        #1;
        check_reset_outputs("rst1");
        @(negedge CLK);
        RESET = 1'b0;
        check_no_done("rst1", 25);
        run_pat(8'hA5, 8'h55, 1'b0, 40'd0, 18, scd_word, resp0, sce_tr, busy_tr, done_tr);
        check("rst1 next resp", 64'(bus.resp), 64'hAA);
        check("rst1 next fail", 64'(bus.fail), 64'd1);
        check("rst1 next err",  64'(bus.err_cnt), 64'd1);
        check("rst1 next done", 64'(done_tr), 64'(DONE_EXP));

        // RESET in the 3rd UNLOAD cycle (k = 11).
        @(negedge CLK);
        bus.pat = 8'h3C; bus.exp = 8'h3C; loopback = 1'b1; bus.start = 1'b1;
        @(posedge CLK); @(negedge CLK);
        bus.start = 1'b0;
        repeat (11) begin @(posedge CLK); @(negedge CLK); end
        check("rst2 pre sce",  64'(bus.sce),  64'd1);
        check("rst2 pre busy", 64'(bus.busy), 64'd1);
        RESET = 1'b1;
        #1;
        check_reset_outputs("rst2");
        @(negedge CLK);
        RESET = 1'b0;
        check_no_done("rst2", 25);
        run_pat(8'hC3, 8'hC3, 1'b1, 40'd0, 18, scd_word, resp0, sce_tr, busy_tr, done_tr);
        check("rst2 next resp", 64'(bus.resp), 64'hC3);
        check("rst2 next fail", 64'(bus.fail), 64'd0);
        check("rst2 next err",  64'(bus.err_cnt), 64'd0);

        // 300 failing patterns: ERR_CNT climbs and saturates at 255.
        exp_err = 0;
        for (int i = 0; i < 300; i++) begin
            run_pat(8'hA5, 8'h55, 1'b0, 40'd0, 18, scd_word, resp0, sce_tr, busy_tr, done_tr);
            if (exp_err < 255) exp_err++;
            check($sformatf("sat err %0d", i), 64'(bus.err_cnt), 64'(exp_err));
        end
        check("sat fail", 64'(bus.fail), 64'd1);
        check("sat done", 64'(done_tr), 64'(DONE_EXP));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
